pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It generates the stall and synchronous-clear (CLR) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It produces the EX-stage operand forwarding selects. It sequences the multi-cycle multiply/divide unit and issues the single-cycle HI/LO write-enable pulse that feeds LOWrite/HIWrite into the MEM/WB signal register.

Parameters:
REG_W, 5, register-number width
MUL_CYCLES, 4, multiply execution cycles (≥1)
DIV_CYCLES, 32, divide execution cycles (≥1)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_rs, id_rt  in  REG_W each  source regs of instruction in ID
id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
id_hilo_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
ex_valid  in  1  EX stage holds a live instruction
ex_rs, ex_rt  in  REG_W each  source regs of instruction in EX
ex_memread  in  1  EX instruction is a load
ex_regwrite  in  1  EX instruction writes GPR
ex_wbreg  in  REG_W  EX destination register
ex_br_taken  in  1  branch/jump resolved taken in EX
ex_md_start  in  1  EX instruction is mult/div
ex_md_div  in  1  1 = divide, 0 = multiply (valid with ex_md_start)
mem_valid, mem_regwrite  in  1 each  MEM-stage qualifiers
mem_wbreg  in  REG_W  MEM destination
wb_valid, wb_regwrite  in  1 each  WB-stage qualifiers
wb_wbreg  in  REG_W  WB destination
pc_stall, ifid_stall  out  1 each  hold PC / IF-ID register
ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  synchronous clear to stage registers
fwd_a, fwd_b  out  2 each  EX operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB
md_busy  out  1  mul/div unit executing
md_hilo_we  out  1  one-cycle HI/LO write enable

Behaviour:
- Forwarding is combinational.
  - fwd_a = 10 if mem_valid & mem_regwrite & mem_wbreg≠0 & mem_wbreg==ex_rs.
  - Otherwise fwd_a = 01 if the same conditions hold for the WB stage.
  - Otherwise fwd_a = 00.
  - MEM has priority over WB. fwd_b uses the same rules against ex_rt. Register 0 is never forwarded.
- Load-use hazard (lu): ex_valid & ex_memread & ex_regwrite & ex_wbreg≠0 & ((id_use_rs & id_rs==ex_wbreg) | (id_use_rt & id_rt==ex_wbreg)).
- Mul/div hazard (mh): id_hilo_use & state∈{MUL,DIV}.
- Stall = lu | mh. On stall, without a flush: pc_stall=1, ifid_stall=1, idex_clr=1 (bubble); EX/MEM and MEM/WB advance.
- Flush: ex_br_taken forces ifid_clr=1 and idex_clr=1, with pc_stall=0 and ifid_stall=0. Flush overrides any stall; a stalled ID instruction is squashed.
- exmem_clr and memwb_clr are 0 in normal operation.
- FSM states: IDLE, MUL, DIV, DONE. A counter of width $clog2(max(MUL_CYCLES,DIV_CYCLES)+1) tracks execution cycles.
  - IDLE: when ex_valid & ex_md_start, go to DIV (ex_md_div=1) or MUL, and load counter = DIV_CYCLES-1 or MUL_CYCLES-1.
  - MUL/DIV: decrement the counter each cycle. When counter==0, go to DONE.
  - DONE: go to IDLE unconditionally.
  - md_busy = (state==MUL|DIV), registered state decode.
  - md_hilo_we = (state==DONE): exactly one cycle.
- Latency: start sampled at edge T → md_busy high for N cycles starting after T → md_hilo_we high in the following cycle.
- An instruction with id_hilo_use may leave ID during the DONE cycle, because HI/LO is written at the end of that cycle.
- ex_md_start while not IDLE is impossible by construction, since mh stalls it in ID; it is ignored and flagged by an assertion.
- ex_br_taken & ex_md_start in the same cycle is illegal (one EX instruction); covered by an assertion.
- A taken branch does not abort an in-flight mul/div (older instruction).
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, md_busy=0, md_hilo_we=0.
  - While rst_n=0: all four *_clr outputs =1, pc_stall=ifid_stall=0, fwd_a=fwd_b=00.
  - Reset mid-operation abandons the mul/div with no md_hilo_we pulse.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - fwd select constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01
  - md_state_t enum {IDLE, MUL, DIV, DONE}
  - REG_W default
- One sub-module, md_sequencer, holds the FSM and counter with outputs md_busy, md_hilo_we and state. pipe_hazard_ctrl holds the combinational forwarding and stall/flush logic.

Test Plan:
- Forwarding: add r3 in MEM (mem_wbreg=3) and add r3 in WB, ex_rs=3 → fwd_a=10. Drop MEM regwrite → 01. Set ex_rs=0 with mem_wbreg=0 → 00.
- Load-use: ex_memread, ex_wbreg=5, id_rs=5, id_use_rs=1 → pc_stall=ifid_stall=idex_clr=1 for exactly 1 cycle. With id_use_rs=0 → no stall.
- Divide: ex_md_start, ex_md_div=1 at T, id_hilo_use held → md_busy 32 cycles, stall 32 cycles, md_hilo_we=1 on cycle T+33, stall drops in that cycle. Repeat with multiply → 4 busy cycles.
- Branch vs stall: load-use and ex_br_taken together → ifid_clr=idex_clr=1, pc_stall=0. Branch during DIV → md_busy unaffected, md_hilo_we still pulses.
- Reset: drop rst_n mid-DIV (counter=10) → immediate md_busy=0, all *_clr=1. Release → IDLE, no md_hilo_we pulse.
- Back-to-back: multiply start immediately in the cycle after DONE → accepted, second md_hilo_we pulse after 4 further busy cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, the mul/div sequencer state type and the default register
// number width.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int DEF_REG_W = 5;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_if
// Bundle of pipeline-stage information flowing into the hazard controller
// and the stall / clear / forwarding / mul-div controls flowing back out.
//   slave  : hazard controller side (stage info in, controls out)
//   master : pipeline side (stage info out, controls in)
// ---------------------------------------------------------------------------
interface pipe_hazard_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
);
    // ID stage
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_hilo_use;
    // EX stage
    logic             ex_valid;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             ex_memread;
    logic             ex_regwrite;
    logic [REG_W-1:0] ex_wbreg;
    logic             ex_br_taken;
    logic             ex_md_start;
    logic             ex_md_div;
    // MEM stage
    logic             mem_valid;
    logic             mem_regwrite;
    logic [REG_W-1:0] mem_wbreg;
    // WB stage
    logic             wb_valid;
    logic             wb_regwrite;
    logic [REG_W-1:0] wb_wbreg;
    // Controls
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_clr;
    logic             idex_clr;
    logic             exmem_clr;
    logic             memwb_clr;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             md_busy;
    logic             md_hilo_we;

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_use,
        input  ex_valid, ex_rs, ex_rt, ex_memread, ex_regwrite, ex_wbreg,
        input  ex_br_taken, ex_md_start, ex_md_div,
        input  mem_valid, mem_regwrite, mem_wbreg,
        input  wb_valid, wb_regwrite, wb_wbreg,
        output pc_stall, ifid_stall, ifid_clr, idex_clr, exmem_clr, memwb_clr,
        output fwd_a, fwd_b, md_busy, md_hilo_we
    );

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_use,
        output ex_valid, ex_rs, ex_rt, ex_memread, ex_regwrite, ex_wbreg,
        output ex_br_taken, ex_md_start, ex_md_div,
        output mem_valid, mem_regwrite, mem_wbreg,
        output wb_valid, wb_regwrite, wb_wbreg,
        input  pc_stall, ifid_stall, ifid_clr, idex_clr, exmem_clr, memwb_clr,
        input  fwd_a, fwd_b, md_busy, md_hilo_we
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
// Multi-cycle multiply/divide sequencer. A start accepted in IDLE keeps the
// unit busy for MUL_CYCLES or DIV_CYCLES cycles, then spends one DONE cycle
// in which the HI/LO write enable is high.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, is_div  : launch request (only honoured in IDLE) and op type
//   md_busy        : registered, high while in MUL or DIV
//   md_hilo_we     : registered, high for the single DONE cycle
//   state          : current sequencer state
// ---------------------------------------------------------------------------
module md_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    input  logic      is_div,
    output logic      md_busy,
    output logic      md_hilo_we,
    output md_state_t state
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             we_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            we_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    we_reg <= 1'b0;
                    if (start) begin
                        state_reg <= is_div ? DIV : MUL;
                        cnt_reg   <= is_div ? DIV_LOAD : MUL_LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                MUL, DIV: begin
                    // The counter holds the number of busy cycles still to
                    // follow the current one.
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        we_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    we_reg    <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    we_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign state      = state_reg;
    assign md_busy    = busy_reg;
    assign md_hilo_we = we_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard controller for the 5-stage pipeline: EX operand forwarding
// selects, load-use and HI/LO stalls, branch flushes, and sequencing of the
// multi-cycle mul/div unit.
// Ports:
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : pipe_hazard_if slave modport (stage info in, controls out)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W      = DEF_REG_W,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_hazard_if.slave  bus
);

    md_state_t  md_state;
    logic       md_busy;
    logic       md_hilo_we;
    logic       md_start;

    logic [REG_W-1:0] ex_src [2];
    logic [1:0]       fwd_sel [2];

    logic mem_fwd_ok;
    logic wb_fwd_ok;
    logic load_use;
    logic hilo_haz;
    logic stall;
    logic flush;

    assign md_start = bus.ex_valid & bus.ex_md_start;

    md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (md_start),
        .is_div     (bus.ex_md_div),
        .md_busy    (md_busy),
        .md_hilo_we (md_hilo_we),
        .state      (md_state)
    );

    // Register 0 is hard-wired zero, so a write to it must never be forwarded.
    assign mem_fwd_ok = bus.mem_valid & bus.mem_regwrite & (bus.mem_wbreg != '0);
    assign wb_fwd_ok  = bus.wb_valid  & bus.wb_regwrite  & (bus.wb_wbreg  != '0);

    assign ex_src[0] = bus.ex_rs;
    assign ex_src[1] = bus.ex_rt;

    // One forwarding mux per EX operand; the younger MEM result wins over WB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_sel[gi] = FWD_RF;
                if (mem_fwd_ok && (bus.mem_wbreg == ex_src[gi])) begin
                    fwd_sel[gi] = FWD_MEM;
                end else if (wb_fwd_ok && (bus.wb_wbreg == ex_src[gi])) begin
                    fwd_sel[gi] = FWD_WB;
                end
            end
        end
    endgenerate

    assign load_use = bus.ex_valid & bus.ex_memread & bus.ex_regwrite &
                      (bus.ex_wbreg != '0) &
                      ((bus.id_use_rs & (bus.id_rs == bus.ex_wbreg)) |
                       (bus.id_use_rt & (bus.id_rt == bus.ex_wbreg)));

    // HI/LO readers may leave ID in the DONE cycle: the write lands at its end.
    assign hilo_haz = bus.id_hilo_use & ((md_state == MUL) | (md_state == DIV));
    assign stall    = load_use | hilo_haz;
    assign flush    = bus.ex_br_taken;

    // While in reset every stage register is held clear and nothing stalls.
    assign bus.pc_stall   = rst_n & stall & ~flush;
    assign bus.ifid_stall = rst_n & stall & ~flush;
    assign bus.ifid_clr   = ~rst_n | flush;
    assign bus.idex_clr   = ~rst_n | flush | stall;
    assign bus.exmem_clr  = ~rst_n;
    assign bus.memwb_clr  = ~rst_n;
    assign bus.fwd_a      = rst_n ? fwd_sel[0] : FWD_RF;
    assign bus.fwd_b      = rst_n ? fwd_sel[1] : FWD_RF;
    assign bus.md_busy    = md_busy;
    assign bus.md_hilo_we = md_hilo_we;

    // A mul/div cannot reach EX while the unit is busy because hilo_haz
    // holds it in ID; a branch and a mul/div cannot share the EX slot.
    a_start_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(md_start && (md_state != IDLE)));
    a_no_branch_with_md: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.ex_valid && bus.ex_br_taken && bus.ex_md_start));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Each step drives the inputs just
// after a rising edge, queues the expected control vector, and compares it
// against the DUT at the following falling edge.
// Vector layout: {pc_stall, ifid_stall, ifid_clr, idex_clr, exmem_clr,
//                 memwb_clr, fwd_a[1:0], fwd_b[1:0], md_busy, md_hilo_we}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_hazard_if #(.REG_W(5)) bus ();

    pipe_hazard_ctrl #(
        .REG_W      (5),
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    localparam logic [11:0] RST_VEC = 12'b00_1111_00_00_00;

    // Expected vector with exmem_clr/memwb_clr at 0 (normal operation)
    function automatic logic [11:0] ev(input logic pc, input logic ifs,
                                       input logic ifc, input logic idc,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic busy, input logic we);
        return {pc, ifs, ifc, idc, 1'b0, 1'b0, fa, fb, busy, we};
    endfunction

    function automatic logic [11:0] observed();
        return {bus.pc_stall, bus.ifid_stall, bus.ifid_clr, bus.idex_clr,
                bus.exmem_clr, bus.memwb_clr, bus.fwd_a, bus.fwd_b,
                bus.md_busy, bus.md_hilo_we};
    endfunction

    // Queue expectation, compare at the falling edge, return to just after
    // the next rising edge ready for the next drive.
    task automatic chk(input string tag, input logic [11:0] v);
        exp_t e;
        logic [11:0] obs;
        exp_q.push_back('{tag, v});
        @(negedge clk);
        e   = exp_q.pop_front();
        obs = observed();
        total++;
        assert (obs === e.val) begin
            passed++;
            $display("check %-16s observed %b expected %b ok", e.tag, obs, e.val);
        end else begin
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs = '0;  bus.id_rt = '0;  bus.id_use_rs = 1'b0;  bus.id_use_rt = 1'b0;
        bus.id_hilo_use = 1'b0;
        bus.ex_valid = 1'b1;  bus.ex_rs = '0;  bus.ex_rt = '0;  bus.ex_memread = 1'b0;
        bus.ex_regwrite = 1'b0;  bus.ex_wbreg = '0;  bus.ex_br_taken = 1'b0;
        bus.ex_md_start = 1'b0;  bus.ex_md_div = 1'b0;
        bus.mem_valid = 1'b1;  bus.mem_regwrite = 1'b0;  bus.mem_wbreg = '0;
        bus.wb_valid = 1'b1;  bus.wb_regwrite = 1'b0;  bus.wb_wbreg = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset: controls forced, forwarding suppressed ----
        idle_inputs();
        rst_n = 1'b0;
        bus.mem_regwrite = 1'b1;  bus.mem_wbreg = 5'd3;  bus.ex_rs = 5'd3;
        chk("reset_state", RST_VEC);
        rst_n = 1'b1;

        // ---------------- forwarding ----------------
        bus.wb_regwrite = 1'b1;  bus.wb_wbreg = 5'd3;  bus.ex_rt = 5'd7;
        chk("fwd_a_mem", ev(0,0,0,0, 2'b10, 2'b00, 0,0));
        bus.mem_regwrite = 1'b0;
        chk("fwd_a_wb", ev(0,0,0,0, 2'b01, 2'b00, 0,0));
        bus.mem_regwrite = 1'b1;  bus.mem_wbreg = 5'd0;  bus.wb_wbreg = 5'd0;
        bus.ex_rs = 5'd0;  bus.ex_rt = 5'd0;
        chk("fwd_r0", ev(0,0,0,0, 2'b00, 2'b00, 0,0));
        bus.mem_valid = 1'b0;  bus.mem_wbreg = 5'd4;  bus.wb_wbreg = 5'd4;  bus.ex_rt = 5'd4;
        chk("fwd_b_mem_inval", ev(0,0,0,0, 2'b00, 2'b01, 0,0));
        bus.mem_valid = 1'b1;
        chk("fwd_b_mem", ev(0,0,0,0, 2'b00, 2'b10, 0,0));
        idle_inputs();

        // ---------------- load-use ----------------
        bus.ex_memread = 1'b1;  bus.ex_regwrite = 1'b1;  bus.ex_wbreg = 5'd5;
        bus.id_rs = 5'd5;  bus.id_use_rs = 1'b1;
        chk("lu_rs_stall", ev(1,1,0,1, 2'b00, 2'b00, 0,0));
        bus.ex_valid = 1'b0;   // load moved on, bubble now in EX
        chk("lu_released", ev(0,0,0,0, 2'b00, 2'b00, 0,0));
        bus.ex_valid = 1'b1;  bus.id_use_rs = 1'b0;
        chk("lu_rs_unused", ev(0,0,0,0, 2'b00, 2'b00, 0,0));
        bus.id_rt = 5'd5;  bus.id_use_rt = 1'b1;
        chk("lu_rt_stall", ev(1,1,0,1, 2'b00, 2'b00, 0,0));
        bus.ex_wbreg = 5'd0;  bus.id_rt = 5'd0;
        chk("lu_r0_nostall", ev(0,0,0,0, 2'b00, 2'b00, 0,0));

        // ---------------- branch overrides load-use ----------------
        bus.ex_wbreg = 5'd5;  bus.id_rt = 5'd5;  bus.ex_br_taken = 1'b1;
        chk("br_vs_lu", ev(0,0,1,1, 2'b00, 2'b00, 0,0));
        idle_inputs();

        // ---------------- divide, with branch mid-flight ----------------
        bus.ex_md_start = 1'b1;  bus.ex_md_div = 1'b1;  bus.id_hilo_use = 1'b1;
        chk("div_start", ev(0,0,0,0, 2'b00, 2'b00, 0,0));
        bus.ex_md_start = 1'b0;  bus.ex_md_div = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                bus.ex_br_taken = 1'b1;
                chk("div_branch", ev(0,0,1,1, 2'b00, 2'b00, 1,0));
                bus.ex_br_taken = 1'b0;
            end else begin
                chk($sformatf("div_busy_%0d", i), ev(1,1,0,1, 2'b00, 2'b00, 1,0));
            end
        end
        chk("div_done", ev(0,0,0,0, 2'b00, 2'b00, 0,1));
        chk("div_idle", ev(0,0,0,0, 2'b00, 2'b00, 0,0));

        // ---------------- multiply, then back-to-back multiply ----------
        bus.ex_md_start = 1'b1;
        chk("mul1_start", ev(0,0,0,0, 2'b00, 2'b00, 0,0));
        bus.ex_md_start = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("mul1_busy_%0d", i), ev(1,1,0,1, 2'b00, 2'b00, 1,0));
        chk("mul1_done", ev(0,0,0,0, 2'b00, 2'b00, 0,1));
        bus.ex_md_start = 1'b1;
        chk("mul2_start", ev(0,0,0,0, 2'b00, 2'b00, 0,0));
        bus.ex_md_start = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("mul2_busy_%0d", i), ev(1,1,0,1, 2'b00, 2'b00, 1,0));
        chk("mul2_done", ev(0,0,0,0, 2'b00, 2'b00, 0,1));
        chk("mul2_idle", ev(0,0,0,0, 2'b00, 2'b00, 0,0));

        // ---------------- reset mid-divide (counter at 10) ----------------
        bus.ex_md_start = 1'b1;  bus.ex_md_div = 1'b1;
        chk("div2_start", ev(0,0,0,0, 2'b00, 2'b00, 0,0));
        bus.ex_md_start = 1'b0;  bus.ex_md_div = 1'b0;
        for (int i = 0; i < 21; i++)
            chk($sformatf("div2_busy_%0d", i), ev(1,1,0,1, 2'b00, 2'b00, 1,0));
        rst_n = 1'b0;
        chk("div2_reset", RST_VEC);
        chk("div2_reset_hold", RST_VEC);
        rst_n = 1'b1;
        for (int i = 0; i < 36; i++)
            chk($sformatf("post_rst_%0d", i), ev(0,0,0,0, 2'b00, 2'b00, 0,0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
